// File: rtl/input_conditioner_if.sv
// Raw board inputs and conditioned outputs of input_conditioner.
// master drives the raw inputs; slave is the conditioner itself.
interface input_conditioner_if;
  logic a_raw;
  logic b_raw;
  logic A;
  logic B;
  logic a_rise;
  logic a_fall;
  logic b_rise;
  logic b_fall;
  logic busy;

  modport master (
    output a_raw, b_raw,
    input  A, B, a_rise, a_fall,
    input  b_rise, b_fall, busy
  );

  modport slave (
    input  a_raw, b_raw,
    output A, B, a_rise, a_fall,
    output b_rise, b_fall, busy
  );
endinterface

// File: rtl/input_conditioner.sv
// Two-channel 2-flop synchronizer plus debounce FSM per channel.
// Edge pulses built only with INPUT_CONDITIONER_EDGE_PULSE_EN.
module input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 3
) (
  input  logic                clock,
  input  logic                reset,
  input_conditioner_if.slave  bus
);

  typedef enum logic [1:0] {
    ST0 = 2'd0,
    RW  = 2'd1,
    ST1 = 2'd2,
    FW  = 2'd3
  } st_e;

  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       w_raw;
  logic [1:0]       r_s1;
  logic [1:0]       r_s2;
  st_e              r_st  [2];
  st_e              w_nxt [2];
  logic [CNT_W-1:0] r_cnt [2];
  logic [CNT_W-1:0] w_cnt [2];
  logic [1:0]       w_wait;
  logic [1:0]       w_lvl;

  assign w_raw = {bus.b_raw, bus.a_raw};

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_s1 <= 2'b00;
      r_s2 <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        r_st[i]  <= ST0;
        r_cnt[i] <= '0;
      end
    end else begin
      r_s1 <= w_raw;
      r_s2 <= r_s1;
      for (int i = 0; i < 2; i++) begin
        r_st[i]  <= w_nxt[i];
        r_cnt[i] <= w_cnt[i];
      end
    end
  end

  // Counter is cleared on every return to a stable state
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      w_nxt[i] = r_st[i];
      w_cnt[i] = r_cnt[i];
      unique case (r_st[i])
        ST0: begin
          if (r_s2[i]) begin
            w_nxt[i] = RW;
            w_cnt[i] = CNT_W'(1);
          end
        end
        RW: begin
          if (!r_s2[i]) begin
            w_nxt[i] = ST0;
            w_cnt[i] = '0;
          end else if (r_cnt[i] == CNT_MAX) begin
            w_nxt[i] = ST1;
            w_cnt[i] = '0;
          end else begin
            w_cnt[i] = r_cnt[i] + CNT_W'(1);
          end
        end
        ST1: begin
          if (!r_s2[i]) begin
            w_nxt[i] = FW;
            w_cnt[i] = CNT_W'(1);
          end
        end
        FW: begin
          if (r_s2[i]) begin
            w_nxt[i] = ST1;
            w_cnt[i] = '0;
          end else if (r_cnt[i] == CNT_MAX) begin
            w_nxt[i] = ST0;
            w_cnt[i] = '0;
          end else begin
            w_cnt[i] = r_cnt[i] + CNT_W'(1);
          end
        end
        default: begin
          w_nxt[i] = ST0;
          w_cnt[i] = '0;
        end
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      w_wait[i] = (r_st[i] == RW) || (r_st[i] == FW);
      w_lvl[i]  = (r_st[i] == ST1) || (r_st[i] == FW);
    end
  end

  assign bus.A    = w_lvl[0];
  assign bus.B    = w_lvl[1];
  assign bus.busy = |w_wait;

`ifdef INPUT_CONDITIONER_EDGE_PULSE_EN
  logic [1:0] w_rise;
  logic [1:0] w_fall;
  logic [1:0] r_rise;
  logic [1:0] r_fall;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      w_rise[i] = (r_st[i] == RW) && r_s2[i] &&
                  (r_cnt[i] == CNT_MAX);
      w_fall[i] = (r_st[i] == FW) && !r_s2[i] &&
                  (r_cnt[i] == CNT_MAX);
    end
  end

  // Pulses land on the same edge as the new level
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_rise <= 2'b00;
      r_fall <= 2'b00;
    end else begin
      r_rise <= w_rise;
      r_fall <= w_fall;
    end
  end

  assign bus.a_rise = r_rise[0];
  assign bus.a_fall = r_fall[0];
  assign bus.b_rise = r_rise[1];
  assign bus.b_fall = r_fall[1];
`else
  assign bus.a_rise = 1'b0;
  assign bus.a_fall = 1'b0;
  assign bus.b_rise = 1'b0;
  assign bus.b_fall = 1'b0;
`endif

endmodule

// File: tb/tb_input_conditioner.sv
// Randomized scoreboard bench for input_conditioner.
// Driver pushes model predictions; monitor pops and compares.
module tb_input_conditioner;

  localparam int D      = 4;
  localparam int NCYC   = 3000;
  localparam int DIRECT = 24;

  logic clk = 1'b0;
  logic rst_n;

  input_conditioner_if ic ();

  input_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W(3)
  ) dut (
    .clock(clk),
    .reset(rst_n),
    .bus(ic.slave)
  );

  always #5 clk = ~clk;

  logic [6:0] exp_q [$];
  int checks = 0;
  int errors = 0;

  // Model: sync pipeline, level, and length of current
  // run of synchronized samples disagreeing with the level.
  int m_s1  [2];
  int m_s2  [2];
  int m_out [2];
  int m_run [2];
  int m_rise[2];
  int m_fall[2];

  function automatic logic [6:0] model_step(
    input logic rst, input logic ra, input logic rb);
    int raw [2];
    int samp;
    logic [6:0] e;
    raw[0] = int'(ra);
    raw[1] = int'(rb);
    for (int i = 0; i < 2; i++) begin
      m_rise[i] = 0;
      m_fall[i] = 0;
      if (!rst) begin
        m_s1[i]  = 0;
        m_s2[i]  = 0;
        m_out[i] = 0;
        m_run[i] = 0;
      end else begin
        samp    = m_s2[i];
        m_s2[i] = m_s1[i];
        m_s1[i] = raw[i];
        if (samp != m_out[i]) begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] == D) begin
            m_out[i] = samp;
            m_run[i] = 0;
            if (samp == 1) m_rise[i] = 1;
            else m_fall[i] = 1;
          end
        end else begin
          m_run[i] = 0;
        end
      end
    end
`ifndef INPUT_CONDITIONER_EDGE_PULSE_EN
    for (int i = 0; i < 2; i++) begin
      m_rise[i] = 0;
      m_fall[i] = 0;
    end
`endif
    e[6] = (m_out[0] != 0);
    e[5] = (m_out[1] != 0);
    e[4] = (m_rise[0] != 0);
    e[3] = (m_fall[0] != 0);
    e[2] = (m_rise[1] != 0);
    e[1] = (m_fall[1] != 0);
    e[0] = (m_run[0] != 0) || (m_run[1] != 0);
    return e;
  endfunction

  // Driver: inputs change mid-cycle, prediction queued before edge
  initial begin
    logic ra;
    logic rb;
    int   k;
    for (int i = 0; i < 2; i++) begin
      m_s1[i]  = 0;
      m_s2[i]  = 0;
      m_out[i] = 0;
      m_run[i] = 0;
    end
    ra = 1'b1;
    rb = 1'b1;
    k  = 2;
    for (int c = 0; c < NCYC; c++) begin
      if (c < 2) begin
        rst_n = 1'b0;
      end else if (c < DIRECT) begin
        rst_n = 1'b1;
      end else begin
        if ((c % 250) == 0) k = 2 << ((c / 250) % 4);
        rst_n = ($urandom_range(0, 299) != 0);
        if ($urandom_range(0, k - 1) == 0) ra = ~ra;
        if ($urandom_range(0, k - 1) == 0) rb = ~rb;
        if ($urandom_range(0, 15) == 0) begin
          ra = ~ra;
          rb = ~rb;
        end
      end
      ic.a_raw = ra;
      ic.b_raw = rb;
      exp_q.push_back(model_step(rst_n, ra, rb));
      @(negedge clk);
    end
  end

  // Monitor: one output observation per clock
  initial begin
    logic [6:0] got;
    logic [6:0] exp;
    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      #1;
      got = {ic.A, ic.B, ic.a_rise, ic.a_fall,
             ic.b_rise, ic.b_fall, ic.busy};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL cycle %0d: scoreboard empty, got %b",
                 c, got);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          errors++;
          $display({"FAIL cycle %0d: {A,B,ar,af,br,bf,busy}",
                    " got %b expected %b"}, c, got, exp);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0",
               exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
